ysyx_24100006_lsu: RTL

Parametrised, handshaked load/store unit that replaces the single-cycle combinational memory stage. Accepts one memory op per transaction from EXU over valid/ready and drives a request/response memory bus. Handles sub-word alignment (address align, strobe shift, read shift with sign/zero extend), detects misalignment and bus errors, and forwards a result plus opaque sideband payload to WBU over valid/ready. One transaction in flight at a time.

---
 rtl/ysyx_24100006_lsu_if.sv | 61 ++++++
 rtl/ysyx_24100006_lsu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_lsu_if.sv
// ysyx_24100006_lsu_if: bundles the EXU->LSU op channel, the LSU->WBU result
// channel and the LSU memory request/response bus.
// master = LSU side, slave = the surrounding pipeline / memory side.
interface ysyx_24100006_lsu_if #(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 32,
    parameter int PAYLOAD_W = 96
);
    localparam int NB = XLEN / 8;

    // EXU -> LSU
    logic                 in_valid;
    logic                 in_ready;
    logic [ADDR_W-1:0]    in_addr;
    logic [XLEN-1:0]      in_wdata;
    logic                 in_load;
    logic                 in_store;
    logic [1:0]           in_size;
    logic                 in_unsigned;
    logic [PAYLOAD_W-1:0] in_payload;

    // LSU -> WBU
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_rdata;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [1:0]           out_fault;

    // memory bus
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_req_we;
    logic [ADDR_W-1:0]    mem_req_addr;
    logic [XLEN-1:0]      mem_req_wdata;
    logic [NB-1:0]        mem_req_wstrb;
    logic                 mem_resp_valid;
    logic [XLEN-1:0]      mem_resp_rdata;
    logic                 mem_resp_err;

    modport master (
        input  in_valid, in_addr, in_wdata, in_load, in_store, in_size,
               in_unsigned, in_payload,
        output in_ready,
        output out_valid, out_rdata, out_payload, out_fault,
        input  out_ready,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               mem_req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

    modport slave (
        output in_valid, in_addr, in_wdata, in_load, in_store, in_size,
               in_unsigned, in_payload,
        input  in_ready,
        input  out_valid, out_rdata, out_payload, out_fault,
        output out_ready,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               mem_req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );
endinterface

// File: rtl/ysyx_24100006_lsu.sv
// ysyx_24100006_lsu: handshaked load/store unit, one op in flight.
// IDLE accepts an op; legal memory ops go REQ -> WAIT -> OUT, non-memory and
// misaligned ops go straight to OUT. Sub-word stores are shifted onto the
// aligned beat with a byte strobe; loads are shifted down and extended.
// Optional macro LSU_TIMEOUT_EN adds a response watchdog (fault 3).
module ysyx_24100006_lsu #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int PAYLOAD_W   = 96,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                 clk,
    input logic                 reset,
    ysyx_24100006_lsu_if.master bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFS_W = $clog2(NB);

    localparam logic [1:0] F_NONE  = 2'd0;
    localparam logic [1:0] F_ALIGN = 2'd1;
    localparam logic [1:0] F_BUS   = 2'd2;
`ifdef LSU_TIMEOUT_EN
    localparam logic [1:0] F_TMO   = 2'd3;
`endif

    // elaboration-time parameter sanity
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("XLEN must be 32 or 64");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
    state_t state, state_nx;

    // captured op
    logic [ADDR_W-1:0]    addr_q;
    logic [XLEN-1:0]      wdata_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic                 load_q;
    logic                 store_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [XLEN-1:0]      rdata_q;
    logic [1:0]           fault_q;

    logic                 accept;
    logic                 in_mem;
    logic                 in_misaligned;
    logic                 resp_take;
    logic                 timeout_hit;
    logic [OFS_W-1:0]     offset;
    logic [NB-1:0]        size_mask;
    logic [XLEN-1:0]      rd_shift;
    logic [XLEN-1:0]      rd_ext;
    logic                 rd_sign;
    int                   ext_w;

    assign accept    = bus.in_valid && (state == IDLE);
    assign in_mem    = bus.in_load | bus.in_store;
    assign resp_take = (state == WAIT) && bus.mem_resp_valid;
    assign offset    = addr_q[OFS_W-1:0];

    // alignment check on the incoming op; dword is illegal on a 32-bit LSU
    always_comb begin
        in_misaligned = 1'b0;
        case (bus.in_size)
            2'd0: in_misaligned = 1'b0;
            2'd1: in_misaligned = bus.in_addr[0];
            2'd2: in_misaligned = |bus.in_addr[1:0];
            2'd3: in_misaligned = (XLEN == 32) ? 1'b1 : (|bus.in_addr[2:0]);
            default: in_misaligned = 1'b0;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;

    // watchdog: restarts on entering WAIT, counts silent WAIT cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tcnt <= '0;
        else if (state == REQ && bus.mem_req_ready)
            tcnt <= '0;
        else if (state == WAIT && !bus.mem_resp_valid)
            tcnt <= tcnt + 1'b1;
    end

    assign timeout_hit = (state == WAIT) && !bus.mem_resp_valid &&
                         (tcnt == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.in_valid)
                      state_nx = (!in_mem || in_misaligned) ? OUT : REQ;
            REQ:  if (bus.mem_req_ready) state_nx = WAIT;
            WAIT: if (bus.mem_resp_valid || timeout_hit) state_nx = OUT;
            OUT:  if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // handshake outputs decoded from state
    always_comb begin
        bus.in_ready      = 1'b0;
        bus.out_valid     = 1'b0;
        bus.mem_req_valid = 1'b0;
        case (state)
            IDLE: bus.in_ready      = 1'b1;
            REQ:  bus.mem_req_valid = 1'b1;
            OUT:  bus.out_valid     = 1'b1;
            default: ;
        endcase
    end

    // byte-lane mask for the access size, before shifting to the offset
    always_comb begin
        size_mask = '0;
        for (int i = 0; i < NB; i++)
            size_mask[i] = (i < (1 << size_q));
    end

    // load path: move addressed bytes to bit 0, then sign/zero extend
    always_comb begin
        rd_shift = bus.mem_resp_rdata >> {offset, 3'b000};
        ext_w    = 8 << size_q;
        rd_sign  = 1'b0;
        case (size_q)
            2'd0: rd_sign = rd_shift[7];
            2'd1: rd_sign = rd_shift[15];
            2'd2: rd_sign = rd_shift[31];
            default: rd_sign = rd_shift[XLEN-1];
        endcase
        rd_sign = rd_sign & ~uns_q;
        rd_ext  = '0;
        for (int i = 0; i < XLEN; i++)
            rd_ext[i] = (i < ext_w) ? rd_shift[i] : rd_sign;
    end

    // op capture and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            payload_q <= '0;
            rdata_q   <= '0;
            fault_q   <= F_NONE;
        end else if (accept) begin
            addr_q    <= bus.in_addr;
            wdata_q   <= bus.in_wdata;
            size_q    <= bus.in_size;
            uns_q     <= bus.in_unsigned;
            load_q    <= bus.in_load;
            store_q   <= bus.in_store;
            payload_q <= bus.in_payload;
            rdata_q   <= '0;
            fault_q   <= (in_mem && in_misaligned) ? F_ALIGN : F_NONE;
        end else if (resp_take) begin
            if (bus.mem_resp_err) begin
                rdata_q <= '0;
                fault_q <= F_BUS;
            end else begin
                rdata_q <= load_q ? rd_ext : '0;
                fault_q <= F_NONE;
            end
        end
`ifdef LSU_TIMEOUT_EN
        else if (timeout_hit) begin
            rdata_q <= '0;
            fault_q <= F_TMO;
        end
`endif
    end

    // request fields come from captured regs, so they hold while REQ stalls;
    // a simultaneous load+store is treated as a load (read)
    assign bus.mem_req_we    = store_q & ~load_q;
    assign bus.mem_req_addr  = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    assign bus.mem_req_wdata = wdata_q << {offset, 3'b000};
    assign bus.mem_req_wstrb = bus.mem_req_we ? (size_mask << offset) : '0;

    assign bus.out_rdata   = rdata_q;
    assign bus.out_payload = payload_q;
    assign bus.out_fault   = fault_q;
endmodule
